// File: rtl/traffic_pkg.sv
// Shared types, lamp encodings and helpers for the traffic phase sequencer.
package traffic_pkg;

  localparam int unsigned BCD_W  = 8;
  localparam int unsigned LAMP_W = 3;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5,
    NIGHT = 3'd6
  } phase_e;

  localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;
  localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

  typedef struct packed {
    logic [LAMP_W-1:0] ns;
    logic [LAMP_W-1:0] ew;
  } lamp_pair_t;

  // True when both nibbles are decimal digits.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Normal-cycle successor; NIGHT is left via RED_B so it maps there too.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      NS_G:    return NS_Y;
      NS_Y:    return RED_A;
      RED_A:   return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return RED_B;
      RED_B:   return NS_G;
      default: return RED_B;
    endcase
  endfunction

  // Lamp pattern shown in a phase; flash only matters in NIGHT.
  function automatic lamp_pair_t phase_lamps(input phase_e p, input logic flash);
    lamp_pair_t l;
    case (p)
      NS_G:    l = '{ns: LAMP_GRN, ew: LAMP_RED};
      NS_Y:    l = '{ns: LAMP_YEL, ew: LAMP_RED};
      EW_G:    l = '{ns: LAMP_RED, ew: LAMP_GRN};
      EW_Y:    l = '{ns: LAMP_RED, ew: LAMP_YEL};
      NIGHT:   l = flash ? '{ns: LAMP_YEL, ew: LAMP_YEL} : '{ns: LAMP_OFF, ew: LAMP_OFF};
      default: l = '{ns: LAMP_RED, ew: LAMP_RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/bcd_dec2.sv
// Combinational 2-digit BCD decrement (caller guarantees input is never 00).
module bcd_dec2
  import traffic_pkg::*;
(
  input  logic [BCD_W-1:0] value,
  output logic [BCD_W-1:0] dec_c
);

  // Borrow from the tens digit when the units digit is zero.
  always_comb begin
    dec_c = value;
    if (value[3:0] == 4'd0) begin
      dec_c = {4'(value[7:4] - 4'd1), 4'd9};
    end else begin
      dec_c = {value[7:4], 4'(value[3:0] - 4'd1)};
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection phase controller with BCD phase timer and night flash.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter logic [BCD_W-1:0] GREEN_NS_DEF = 8'h25,
  parameter logic [BCD_W-1:0] GREEN_EW_DEF = 8'h20,
  parameter logic [BCD_W-1:0] YELLOW_DEF   = 8'h03,
  parameter logic [BCD_W-1:0] ALLRED_T     = 8'h02
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              night_mode,
  input  logic [BCD_W-1:0]  cfg_green_ns,
  input  logic [BCD_W-1:0]  cfg_green_ew,
  input  logic [BCD_W-1:0]  cfg_yellow,
  output logic [LAMP_W-1:0] ns_light,
  output logic [LAMP_W-1:0] ew_light,
  output logic [BCD_W-1:0]  count_bcd,
  output logic [2:0]        phase,
  output logic              phase_done
);

  phase_e             state_q, state_d;
  phase_e             succ_c;
  logic               flash_q, flash_d;
  logic [BCD_W-1:0]   count_d;
  logic [BCD_W-1:0]   dec_c;
  logic [BCD_W-1:0]   load_c;
  logic               done_d;
  lamp_pair_t         lamps_d;

  // Invalid BCD falls back to the default; zero is stretched to one tick.
  function automatic logic [BCD_W-1:0] sanitize(input logic [BCD_W-1:0] cfg,
                                                input logic [BCD_W-1:0] def);
    if (!bcd_valid(cfg)) return def;
    if (cfg == 8'h00)    return 8'h01;
    return cfg;
  endfunction

  bcd_dec2 u_dec (
    .value (count_bcd),
    .dec_c (dec_c)
  );

  // Duration to load for the phase that follows the current one.
  always_comb begin
    succ_c = next_phase(state_q);
    load_c = ALLRED_T;
    case (succ_c)
      NS_G:       load_c = sanitize(cfg_green_ns, GREEN_NS_DEF);
      EW_G:       load_c = sanitize(cfg_green_ew, GREEN_EW_DEF);
      NS_Y, EW_Y: load_c = sanitize(cfg_yellow, YELLOW_DEF);
      default:    load_c = ALLRED_T;
    endcase
  end

  // Next-state, timer and lamp decode; night request outranks phase expiry.
  always_comb begin
    state_d = state_q;
    count_d = count_bcd;
    flash_d = flash_q;
    done_d  = 1'b0;
    if (state_q != NIGHT) begin
      if (night_mode) begin
        state_d = NIGHT;
        count_d = 8'h00;
        flash_d = 1'b1;
        done_d  = 1'b1;
      end else if (tick) begin
        if (count_bcd == 8'h01) begin
          state_d = succ_c;
          count_d = load_c;
          done_d  = 1'b1;
        end else begin
          count_d = dec_c;
        end
      end
    end else begin
      if (!night_mode) begin
        state_d = RED_B;
        count_d = ALLRED_T;
        flash_d = 1'b0;
        done_d  = 1'b1;
      end else if (tick) begin
        flash_d = ~flash_q;
      end
    end
    lamps_d = phase_lamps(state_d, flash_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RED_B;
      count_bcd  <= ALLRED_T;
      flash_q    <= 1'b0;
      ns_light   <= LAMP_RED;
      ew_light   <= LAMP_RED;
      phase_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_bcd  <= count_d;
      flash_q    <= flash_d;
      ns_light   <= lamps_d.ns;
      ew_light   <= lamps_d.ew;
      phase_done <= done_d;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: vector table, directed corners, random vs model.
module tb_traffic_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       night_mode;
  logic [7:0] cfg_green_ns;
  logic [7:0] cfg_green_ew;
  logic [7:0] cfg_yellow;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [7:0] count_bcd;
  logic [2:0] phase;
  logic       phase_done;

  int checks   = 0;
  int failures = 0;

  traffic_phase_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .night_mode   (night_mode),
    .cfg_green_ns (cfg_green_ns),
    .cfg_green_ew (cfg_green_ew),
    .cfg_yellow   (cfg_yellow),
    .ns_light     (ns_light),
    .ew_light     (ew_light),
    .count_bcd    (count_bcd),
    .phase        (phase),
    .phase_done   (phase_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (phase position + remaining seconds) ----
  bit m_night;
  int m_idx;     // position in cycle NS_G..RED_B = 0..5
  int m_rem;     // remaining ticks as a plain integer
  bit m_flash;
  bit m_done;

  logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  function automatic int cfg_secs(input logic [7:0] v, input int def);
    int hi, lo, n;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) return def;
    n = hi * 10 + lo;
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int duration(input int idx);
    case (idx)
      0:       return cfg_secs(cfg_green_ns, 25);
      1, 4:    return cfg_secs(cfg_yellow, 3);
      3:       return cfg_secs(cfg_green_ew, 20);
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] b;
    b[7:4] = 4'(n / 10);
    b[3:0] = 4'(n % 10);
    return b;
  endfunction

  task automatic model_reset();
    m_night = 0; m_idx = 5; m_rem = 2; m_flash = 0; m_done = 0;
  endtask

  task automatic model_step(input bit t, input bit n);
    m_done = 0;
    if (!m_night) begin
      if (n) begin
        m_night = 1; m_rem = 0; m_flash = 1; m_done = 1;
      end else if (t) begin
        if (m_rem == 1) begin
          m_idx  = (m_idx + 1) % 6;
          m_rem  = duration(m_idx);
          m_done = 1;
        end else begin
          m_rem = m_rem - 1;
        end
      end
    end else begin
      if (!n) begin
        m_night = 0; m_idx = 5; m_rem = 2; m_done = 1;
      end else if (t) begin
        m_flash = !m_flash;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int ph, input int cnt,
                         input int ns, input int ew, input int dn);
    chk({tag, ".phase"}, int'(phase), ph);
    chk({tag, ".count"}, int'(count_bcd), cnt);
    chk({tag, ".ns"}, int'(ns_light), ns);
    chk({tag, ".ew"}, int'(ew_light), ew);
    chk({tag, ".done"}, int'(phase_done), dn);
  endtask

  task automatic check_model(input string tag);
    int ph, cnt, ns, ew;
    ph  = m_night ? 6 : m_idx;
    cnt = m_night ? 0 : int'(to_bcd(m_rem));
    if (m_night) begin
      ns = m_flash ? 3'b010 : 3'b000;
      ew = ns;
    end else begin
      ns = int'(ns_tab[m_idx]);
      ew = int'(ew_tab[m_idx]);
    end
    chk_out(tag, ph, cnt, ns, ew, int'(m_done));
  endtask

  // One clock with the given tick/night levels; outputs sampled 1ns after the edge.
  task automatic step(input bit t, input bit n);
    tick = t;
    night_mode = n;
    @(posedge clk);
    model_step(t, n);
    #1;
    tick = 1'b0;
  endtask

  task automatic do_reset();
    tick = 1'b0;
    night_mode = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  function automatic logic [7:0] rand_cfg();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'($urandom);
    if (r == 2) return 8'h3A;
    if (r == 3) return 8'h10;
    return {4'd0, 4'($urandom_range(1, 9))};
  endfunction

  typedef struct {
    bit         t;
    bit         n;
    logic [2:0] ph;
    logic [7:0] cnt;
    logic [2:0] ns;
    logic [2:0] ew;
    bit         dn;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int n;
    int pulses;
    int bad_green;
    bit done_seen;
    bit nl;
    int exp_dur [6] = '{25, 3, 2, 20, 3, 2};

    vecs[0]  = '{0, 0, 3'd5, 8'h02, 3'b100, 3'b100, 0};
    vecs[1]  = '{1, 0, 3'd5, 8'h01, 3'b100, 3'b100, 0};
    vecs[2]  = '{1, 0, 3'd0, 8'h25, 3'b001, 3'b100, 1};
    vecs[3]  = '{0, 0, 3'd0, 8'h25, 3'b001, 3'b100, 0};
    vecs[4]  = '{1, 0, 3'd0, 8'h24, 3'b001, 3'b100, 0};
    vecs[5]  = '{0, 1, 3'd6, 8'h00, 3'b010, 3'b010, 1};
    vecs[6]  = '{1, 1, 3'd6, 8'h00, 3'b000, 3'b000, 0};
    vecs[7]  = '{0, 1, 3'd6, 8'h00, 3'b000, 3'b000, 0};
    vecs[8]  = '{1, 1, 3'd6, 8'h00, 3'b010, 3'b010, 0};
    vecs[9]  = '{0, 0, 3'd5, 8'h02, 3'b100, 3'b100, 1};
    vecs[10] = '{1, 0, 3'd5, 8'h01, 3'b100, 3'b100, 0};
    vecs[11] = '{1, 1, 3'd6, 8'h00, 3'b010, 3'b010, 1};
    vecs[12] = '{0, 0, 3'd5, 8'h02, 3'b100, 3'b100, 1};
    vecs[13] = '{1, 0, 3'd5, 8'h01, 3'b100, 3'b100, 0};
    vecs[14] = '{1, 0, 3'd0, 8'h25, 3'b001, 3'b100, 1};

    rst_n = 1'b0;
    tick = 1'b0;
    night_mode = 1'b0;
    cfg_green_ns = 8'h25;
    cfg_green_ew = 8'h20;
    cfg_yellow = 8'h03;

    // Reset values while held in reset, then the directed vector table.
    #12;
    chk_out("reset", 5, 8'h02, 3'b100, 3'b100, 0);
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].t, vecs[i].n);
      chk_out($sformatf("vec%0d", i), int'(vecs[i].ph), int'(vecs[i].cnt),
              int'(vecs[i].ns), int'(vecs[i].ew), int'(vecs[i].dn));
    end

    // Full cycle: per-phase durations and pulse count.
    do_reset();
    step(1, 0);
    step(1, 0);
    chk_out("to_nsg", 0, 8'h25, 3'b001, 3'b100, 1);
    pulses = 0;
    bad_green = 0;
    for (int p = 0; p < 6; p++) begin
      n = 0;
      done_seen = 0;
      while (!done_seen && n < 60) begin
        step(1, 0);
        check_model("cycle");
        n++;
        if (ns_light[0] && ew_light[0]) bad_green++;
        if (phase_done) begin
          done_seen = 1;
          pulses++;
        end
      end
      chk($sformatf("dur_phase%0d", p), n, exp_dur[p]);
    end
    chk("cycle_pulses", pulses, 6);
    chk("cycle_phase_back", int'(phase), 0);

    // Digit borrow: 20 -> 19 and 10 -> 09.
    do_reset();
    step(1, 0);
    step(1, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("borrow_20", int'(count_bcd), 8'h20);
    step(1, 0);
    chk("borrow_19", int'(count_bcd), 8'h19);
    for (int i = 0; i < 9; i++) step(1, 0);
    chk("borrow_10", int'(count_bcd), 8'h10);
    step(1, 0);
    chk("borrow_09", int'(count_bcd), 8'h09);

    // Night entry from EW_G at count 13, flash toggling, exit to RED_B.
    n = 0;
    while (!(phase == 3'd3 && count_bcd == 8'h13) && n < 200) begin
      step(1, 0);
      check_model("to_ew13");
      n++;
    end
    chk("ew13_phase", int'(phase), 3);
    chk("ew13_count", int'(count_bcd), 8'h13);
    step(0, 1);
    chk_out("night_in", 6, 8'h00, 3'b010, 3'b010, 1);
    step(1, 1);
    chk_out("night_off", 6, 8'h00, 3'b000, 3'b000, 0);
    step(1, 1);
    chk_out("night_on", 6, 8'h00, 3'b010, 3'b010, 0);
    step(0, 0);
    chk_out("night_out", 5, 8'h02, 3'b100, 3'b100, 1);

    // Invalid cfg falls back to default; zero cfg gives a one-tick phase.
    cfg_green_ns = 8'h3A;
    do_reset();
    step(1, 0);
    step(1, 0);
    chk_out("cfg_3a", 0, 8'h25, 3'b001, 3'b100, 1);
    cfg_green_ns = 8'h00;
    step(0, 1);
    step(0, 0);
    step(1, 0);
    step(1, 0);
    chk_out("cfg_00", 0, 8'h01, 3'b001, 3'b100, 1);
    step(1, 0);
    chk_out("cfg_00_end", 1, 8'h03, 3'b010, 3'b100, 1);
    cfg_green_ns = 8'h25;

    // Asynchronous reset mid NS_Y, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 5, 8'h02, 3'b100, 3'b100, 0);
    #2;
    rst_n = 1'b1;
    model_reset();
    step(1, 0);
    chk_out("rst_restart1", 5, 8'h01, 3'b100, 3'b100, 0);
    step(1, 0);
    chk_out("rst_restart2", 0, 8'h25, 3'b001, 3'b100, 1);

    // Random ticks, night requests and cfg changes against the model.
    do_reset();
    nl = 0;
    cfg_green_ns = rand_cfg();
    cfg_green_ew = rand_cfg();
    cfg_yellow   = rand_cfg();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) cfg_green_ns = rand_cfg();
      if ($urandom_range(0, 19) == 0) cfg_green_ew = rand_cfg();
      if ($urandom_range(0, 19) == 0) cfg_yellow   = rand_cfg();
      if ($urandom_range(0, 59) == 0) nl = !nl;
      step($urandom_range(0, 2) == 0, nl);
      check_model("rand");
      if (ns_light[0] && ew_light[0]) bad_green++;
    end
    chk("never_both_green", bad_green, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
